// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pkg
// Description : Shared types and constants for the truth-table capture
//               sequencer: FSM state encoding, default arity, table width
//               derivation and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

    // Default function arity and the matching minterm index width
    localparam int NUM_INPUTS_DEF = 7;
    localparam int IDX_W          = NUM_INPUTS_DEF;

    // Drain counter width; covers the supported latency range 0..7
    localparam int DRAIN_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Truth-table width for an n-input function
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tt_delay_line
// Description : DEPTH-stage shift register carrying a {valid, data} pair so a
//               capture strobe lines up with the function-under-test latency.
//               DEPTH = 0 degenerates to a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset have no load when there is no storage
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0]        valid_q;
            logic [DEPTH-1:0]        valid_d;
            logic [DEPTH-1:0][W-1:0] data_q;
            logic [DEPTH-1:0][W-1:0] data_d;

            // Next value of every stage: new pair enters stage 0, rest shift up
            always_comb begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end

            // Stage registers; reset empties the line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tt_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tt_capture_sequencer
// Description : Sweeps every minterm of an N-input function, samples its
//               output through a latency-matched delay line and presents the
//               assembled 2^N-bit truth table on a valid/ready port.
//               Optional macro TT_ONES_EN adds the tt_ones on-set counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_capture_sequencer
    import tt_pkg::*;
#(
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int DUT_LATENCY = 0,
    parameter int TT_W        = tt_width(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [NUM_INPUTS-1:0] x,
    input  logic                  f_in,
    output logic                  tt_valid,
    input  logic                  tt_ready,
    output logic [TT_W-1:0]       tt_data
`ifdef TT_ONES_EN
    ,
    output logic [NUM_INPUTS:0]   tt_ones
`endif
);

    // Last drain-counter value before entering HOLD
    localparam logic [DRAIN_W-1:0] c_drain_last =
        DRAIN_W'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

    state_t                  state_q, state_d;
    logic [NUM_INPUTS-1:0]   idx_q, idx_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic [TT_W-1:0]         tt_data_q, tt_data_d;
    logic                    drive_valid;
    logic                    cap_valid;
    logic [NUM_INPUTS-1:0]   cap_idx;
`ifdef TT_ONES_EN
    logic [NUM_INPUTS:0]     ones_q, ones_d;
`endif

    // Align each driven minterm index with the function output it produces
    tt_delay_line #(
        .DEPTH (DUT_LATENCY),
        .W     (NUM_INPUTS)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (drive_valid),
        .in_data   (idx_q),
        .out_valid (cap_valid),
        .out_data  (cap_idx)
    );

    // Sweep control and table assembly
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        tt_data_d   = tt_data_q;
        drive_valid = 1'b0;
`ifdef TT_ONES_EN
        ones_d      = ones_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DRIVE;
                    idx_d     = '0;
                    tt_data_d = '0;
`ifdef TT_ONES_EN
                    ones_d    = '0;
`endif
                end
            end
            DRIVE: begin
                drive_valid = 1'b1;
                idx_d       = idx_q + 1'b1;
                drain_d     = '0;
                if (idx_q == {NUM_INPUTS{1'b1}}) begin
                    state_d = (DUT_LATENCY > 0) ? DRAIN : HOLD;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == c_drain_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A delayed strobe lands the function output at its minterm position
        if (cap_valid) begin
            tt_data_d[cap_idx] = f_in;
`ifdef TT_ONES_EN
            ones_d = ones_q + {{NUM_INPUTS{1'b0}}, f_in};
`endif
        end
    end

    // State and datapath registers; reset discards any partial sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            drain_q   <= '0;
            tt_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            tt_data_q <= tt_data_d;
        end
    end

`ifdef TT_ONES_EN
    // On-set population counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign tt_ones = ones_q;
`endif

    assign busy     = (state_q != IDLE);
    assign x        = (state_q == DRIVE) ? idx_q : '0;
    assign tt_valid = (state_q == HOLD);
    assign tt_data  = tt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_capture_sequencer
// Description : Scoreboard bench for tt_capture_sequencer. Instance 0 runs
//               with zero function latency, instance 1 with a two-register
//               function pipeline. Expected tables are pushed at start; a
//               negedge monitor checks each presented table.
//               Honours TT_ONES_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_capture_sequencer;

    localparam int N    = 7;
    localparam int TT_W = 128;
    localparam logic [TT_W-1:0] REF_TT   = 128'hfeeaeee8fcc8a880feeaecc0e888a880;
    localparam logic [TT_W-1:0] EXP_X0   = {32{4'ha}};
    localparam logic [TT_W-1:0] EXP_MAJ3 = {16{8'he8}};
    localparam logic [TT_W-1:0] EXP_X6   = {{64{1'b1}}, {64{1'b0}}};
    localparam logic [TT_W-1:0] EXP_ZERO = '0;
    localparam logic [TT_W-1:0] EXP_ONES = '1;

    typedef struct {
        int              dut;
        logic [TT_W-1:0] data;
        int              ones;
        int              rise;
    } sb_t;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            start = 2'b00;
    logic [1:0]            tr    = 2'b11;
    logic [1:0]            busy;
    logic [1:0]            tv;
    logic [1:0][N-1:0]     xv;
    logic [1:0][TT_W-1:0]  td;
    logic                  f0, f1, p1;
`ifdef TT_ONES_EN
    logic [1:0][N:0]       to;
`endif

    int  sel [2];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    sb_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function-under-test models, selected per instance
    function automatic logic fn(input int s, input logic [N-1:0] v);
        logic [TT_W-1:0] r;
        r = REF_TT;
        case (s)
            0:       return v[0];
            1:       return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            2:       return v[6];
            3:       return r[v];
            4:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    assign f0 = fn(sel[0], xv[0]);

    // Instance 1 sees its function through two registers
    always @(posedge clk) begin
        p1 <= fn(sel[1], xv[1]);
        f1 <= p1;
    end

    tt_capture_sequencer #(.NUM_INPUTS(N), .DUT_LATENCY(0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start[0]),
        .busy     (busy[0]),
        .x        (xv[0]),
        .f_in     (f0),
        .tt_valid (tv[0]),
        .tt_ready (tr[0]),
        .tt_data  (td[0])
`ifdef TT_ONES_EN
        ,
        .tt_ones  (to[0])
`endif
    );

    tt_capture_sequencer #(.NUM_INPUTS(N), .DUT_LATENCY(2)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start[1]),
        .busy     (busy[1]),
        .x        (xv[1]),
        .f_in     (f1),
        .tt_valid (tv[1]),
        .tt_ready (tr[1]),
        .tt_data  (td[1])
`ifdef TT_ONES_EN
        ,
        .tt_ones  (to[1])
`endif
    );

    task automatic chk(input string nm, input logic [TT_W-1:0] act, input logic [TT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: timing of tt_valid, stability in HOLD, table content at handshake
    logic [1:0]           pv = 2'b00;
    logic [1:0][TT_W-1:0] pd;
    always @(negedge clk) begin
        sb_t e;
        for (int k = 0; k < 2; k++) begin
            if (tv[k]) begin
                if (q.size() == 0 || q[0].dut != k) begin
                    chk("unexpected_valid", {127'd0, tv[k]}, '0);
                end else begin
                    if (!pv[k]) chk("valid_rise_cycle", cyc, q[0].rise);
                    else        chk("hold_stable", td[k], pd[k]);
                    if (tr[k]) begin
                        e = q.pop_front();
                        chk("tt_data", td[k], e.data);
`ifdef TT_ONES_EN
                        chk("tt_ones", {120'd0, to[k]}, e.ones);
`endif
                    end
                end
            end
            pv[k] <= tv[k];
            pd[k] <= td[k];
        end
    end

    task automatic begin_sweep(input int k, input int fs, input logic [TT_W-1:0] exp,
                               input bit push, output int t);
        sel[k] = fs;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        t        = cyc;
        start[k] = 1'b0;
        if (push) q.push_back('{k, exp, $countones(exp), t + TT_W + lat(k)});
    endtask

    task automatic sweep(input int k, input int fs, input logic [TT_W-1:0] exp);
        int t;
        int done_n;
        done_n = -1;
        begin_sweep(k, fs, exp, 1'b1, t);
        for (int n = 0; n < TT_W + 40; n++) begin
            @(negedge clk);
            if (n == 0 || n == 37 || n == TT_W - 1) chk("x_drive", xv[k], n);
            if (n == TT_W) chk("x_after_drive", xv[k], 0);
            if (!busy[k]) begin
                done_n = n;
                break;
            end
        end
        chk("busy_drop_cycle", done_n, TT_W + lat(k) + 1);
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_busy", busy[k], 0);
        chk("rst_x", xv[k], 0);
        chk("rst_valid", tv[k], 0);
        chk("rst_data", td[k], '0);
`ifdef TT_ONES_EN
        chk("rst_ones", to[k], 0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        sel[0] = 0;
        sel[1] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;

        // Zero-latency instance: several functions
        sweep(0, 0, EXP_X0);
        sweep(0, 1, EXP_MAJ3);
        sweep(0, 2, EXP_X6);

        // Two-cycle latency instance: reference network and x0
        sweep(1, 3, REF_TT);
        sweep(1, 0, EXP_X0);

        // Back-to-back constant tables: no residue from earlier sweeps
        sweep(0, 4, EXP_ZERO);
        sweep(0, 5, EXP_ONES);
        sweep(1, 4, EXP_ZERO);
        sweep(1, 5, EXP_ONES);

        // Backpressure in HOLD with stray start pulses in DRIVE and HOLD
        tr[1] = 1'b0;
        begin_sweep(1, 3, REF_TT, 1'b1, t);
        for (int n = 0; n <= TT_W + 2 + 20; n++) begin
            @(negedge clk);
            start[1] = (n == 30) || (n == TT_W + 2 + 5);
            chk("busy_during_hold", busy[1], 1);
        end
        start[1] = 1'b0;
        tr[1]    = 1'b1;
        @(negedge clk);
        chk("idle_after_ready", busy[1], 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_late_restart", busy[1], 0);
        end

        // Asynchronous reset in the middle of a sweep
        begin_sweep(0, 5, EXP_ONES, 1'b0, t);
        for (int n = 0; n <= 50; n++) begin
            @(negedge clk);
            if (n == 50) chk("x_before_reset", xv[0], 50);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 1, EXP_MAJ3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_capture_sequencer.md
# tt_capture_sequencer

Exhaustive stimulus sequencer and truth-table collector for the 7-input classification functions. Drives every input minterm into a combinational (or pipelined) function-under-test, samples its single-bit output and assembles the full 2^N-bit truth table, e.g. 128'hfeeaeee8fcc8a880feeaecc0e888a880. The result is offered on a valid/ready port to the downstream classifier/signature logging stage. It sits directly upstream of each function block (feeding x0..x6) and directly downstream of it (consuming `out`).

## Interface
- NUM_INPUTS, 7: function arity; truth-table width TT_W = 2^NUM_INPUTS.
- DUT_LATENCY, 0: cycles from `x` change to matching `f_in`; range 0..7.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  out  1  high whenever state is not IDLE.
- x  out  NUM_INPUTS  stimulus to function; x[0] drives x0, LSB.
- f_in  in  1  function output (`out` of the function block).
- tt_valid  out  1  truth table complete and stable.
- tt_ready  in  1  downstream accepts tt_data.
- tt_data  out  TT_W  bit i = f(x = i).
- tt_ones  out  NUM_INPUTS+1  on-set size (only with TT_ONES_EN).

## Operation
- States: IDLE, DRIVE, DRAIN, HOLD.
- IDLE: x = 0. On start: clear tt_data (and tt_ones), idx <= 0, go DRIVE.
- DRIVE: x = idx; idx increments each cycle; after idx = TT_W-1 go DRAIN (DUT_LATENCY > 0) or HOLD (DUT_LATENCY = 0). x returns to 0 on leaving DRIVE.
- Capture: a (valid, index) pair per drive cycle passes through a DUT_LATENCY-deep delay line; when delayed valid is high, tt_data[index] <= f_in.
- DRAIN: exactly DUT_LATENCY cycles, capturing the remaining pairs, then HOLD.
- HOLD: tt_valid = 1, tt_data stable. On tt_valid & tt_ready go IDLE; tt_data retains its value until next start.
- start outside IDLE is ignored; it never restarts or truncates a sweep.
- Reset values: busy 0, x 0, tt_valid 0, tt_data 0, tt_ones 0, state IDLE, delay line empty.
- rst_n low mid-sweep: immediate clear to reset values; no partial table is ever presented.

## Timing
- start sampled at edge t: x = 0 from t+1, x = i at t+1+i, last minterm at t+TT_W.
- f_in for minterm i sampled at edge t+1+i+DUT_LATENCY.
- tt_valid rises at t+TT_W+DUT_LATENCY+1; sweep length TT_W+DUT_LATENCY+1 cycles.
- tt_ready high in the first HOLD cycle: tt_valid high for exactly one cycle; start accepted on the following edge at earliest.
- tt_ready may be held high in advance; no combinational path from tt_ready to any output.

## Configuration
- TT_ONES_EN defined: tt_ones accumulates the count of captured 1 bits (width NUM_INPUTS+1, max TT_W, no overflow); valid alongside tt_valid, cleared on start.
- Undefined: port tt_ones absent, no counter logic.

## Structure
- Package tt_pkg: state enum (IDLE, DRIVE, DRAIN, HOLD), default NUM_INPUTS, TT_W derivation function, index width constant.
- Sub-module tt_delay_line: parameterised shift register carrying {valid, index}; depth 0 is a wire.

## Test plan
- f_in = x[0], DUT_LATENCY 0: tt_data = 128'haaaa…aaaa; tt_valid at start+129; tt_ones = 64.
- f_in = majority(x0,x1,x2): tt_data = 128'he8e8…e8e8; f_in = x[6]: 128'hffff…ffff_0000…0000 (upper 64 bits ones).
- Reference 7-input majority network, f_in registered twice, DUT_LATENCY 2: tt_data = 128'hfeeaeee8fcc8a880feeaecc0e888a880, tt_valid at start+131.
- tt_ready held low 20 cycles in HOLD, start pulsed during DRIVE and HOLD: tt_data unchanged, no restart, busy high throughout, IDLE one cycle after ready.
- rst_n asserted at drive cycle 50: all outputs 0 asynchronously; new start yields full correct table with tt_ones from zero.
- f_in constant 0 then constant 1 on back-to-back sweeps: 128'h0 then all ones (tt_ones 0 then 128), no residue from prior table.
